// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter : round-robin arbiter sharing one single-port memory
//                    between requester A (fetch) and requester B (data).
// Revision 1.0
// ============================================================================
module mem_port_arbiter #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 10,
    parameter int MEM_LAT = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_req_a,
    input  logic               i_req_b,
    input  logic               i_we_a,
    input  logic               i_we_b,
    input  logic [NB_ADDR-1:0] i_addr_a,
    input  logic [NB_ADDR-1:0] i_addr_b,
    input  logic [NB_DATA-1:0] i_wdata_a,
    input  logic [NB_DATA-1:0] i_wdata_b,
    output logic               o_gnt_a,
    output logic               o_gnt_b,
    output logic               o_rvalid_a,
    output logic               o_rvalid_b,
    output logic [NB_DATA-1:0] o_rdata_a,
    output logic [NB_DATA-1:0] o_rdata_b,
    output logic               o_mem_en,
    output logic               o_mem_we,
    output logic [NB_ADDR-1:0] o_mem_addr,
    output logic [NB_DATA-1:0] o_mem_wdata,
    input  logic [NB_DATA-1:0] i_mem_rdata,
    output logic               o_sel,
    output logic               o_busy
);

    localparam int               CNT_W    = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             last_owner;   // 0 = A, 1 = B
    logic             we_q;
    logic             any_req;
    logic             win_b;
    logic             start;
    logic             wait_done;

    assign any_req   = i_req_a | i_req_b;
    // B wins when alone, or on contention when A owned the port last
    assign win_b     = i_req_b & (~i_req_a | ~last_owner);
    assign start     = ((state == ST_IDLE) || (state == ST_RESP)) && any_req;
    assign wait_done = (state == ST_WAIT) && (cnt == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   state_nxt = any_req ? ST_ACCESS : ST_IDLE;
            ST_ACCESS: state_nxt = ST_WAIT;
            ST_WAIT:   state_nxt = wait_done ? ST_RESP : ST_WAIT;
            ST_RESP:   state_nxt = any_req ? ST_ACCESS : ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_mem_en   = 1'b0;
        o_mem_we   = 1'b0;
        o_gnt_a    = 1'b0;
        o_gnt_b    = 1'b0;
        o_rvalid_a = 1'b0;
        o_rvalid_b = 1'b0;
        o_busy     = 1'b0;
        case (state)
            ST_ACCESS: begin
                o_mem_en = 1'b1;
                o_mem_we = we_q;
                o_gnt_a  = ~o_sel;
                o_gnt_b  = o_sel;
                o_busy   = 1'b1;
            end
            ST_WAIT: begin
                o_busy = 1'b1;
            end
            ST_RESP: begin
                o_rvalid_a = ~o_sel;
                o_rvalid_b = o_sel;
                o_busy     = 1'b1;
            end
            default: begin
                o_busy = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_sel       <= 1'b0;
            last_owner  <= 1'b1;
            we_q        <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
        end else if (start) begin
            o_sel       <= win_b;
            last_owner  <= win_b;
            we_q        <= win_b ? i_we_b : i_we_a;
            o_mem_addr  <= win_b ? i_addr_b : i_addr_a;
            o_mem_wdata <= win_b ? i_wdata_b : i_wdata_a;
        end
    end

    // Loaded once per transaction; never wraps because WAIT exits at zero
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= CNT_LOAD;
        end else if ((state == ST_WAIT) && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rdata_a <= '0;
            o_rdata_b <= '0;
        end else if (wait_done && !we_q) begin
            if (o_sel) begin
                o_rdata_b <= i_mem_rdata;
            end else begin
                o_rdata_a <= i_mem_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_port_arbiter : scenario bench for mem_port_arbiter (MEM_LAT = 2).
// Revision 1.0
// ============================================================================
module tb_mem_port_arbiter;

    localparam int NB_DATA = 32;
    localparam int NB_ADDR = 10;
    localparam int MEM_LAT = 2;

    typedef struct {
        logic               port;
        logic [NB_DATA-1:0] data;
    } exp_t;

    typedef struct {
        logic               port;
        logic               we;
        logic [NB_ADDR-1:0] addr;
        logic [NB_DATA-1:0] wdata;
    } txn_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               req_a = 1'b0, req_b = 1'b0, we_a = 1'b0, we_b = 1'b0;
    logic [NB_ADDR-1:0] addr_a = '0, addr_b = '0;
    logic [NB_DATA-1:0] wdata_a = '0, wdata_b = '0;
    logic               gnt_a, gnt_b, rvalid_a, rvalid_b;
    logic [NB_DATA-1:0] rdata_a, rdata_b;
    logic               mem_en, mem_we, sel, busy;
    logic [NB_ADDR-1:0] mem_addr;
    logic [NB_DATA-1:0] mem_wdata;
    logic [NB_DATA-1:0] mem_p1 = '0, mem_rdata = '0;

    int                 checks = 0;
    int                 failures = 0;
    exp_t               sb[$];
    logic [NB_DATA-1:0] model_a = '0, model_b = '0;

    always #5 clk = ~clk;

    // Memory returns addr+100 two cycles after the enable cycle
    always @(posedge clk) begin
        if (mem_en) mem_p1 <= NB_DATA'(mem_addr) + 32'd100;
        mem_rdata <= mem_p1;
    end

    mem_port_arbiter #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR), .MEM_LAT(MEM_LAT)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_a(req_a), .i_req_b(req_b), .i_we_a(we_a), .i_we_b(we_b),
        .i_addr_a(addr_a), .i_addr_b(addr_b), .i_wdata_a(wdata_a), .i_wdata_b(wdata_b),
        .o_gnt_a(gnt_a), .o_gnt_b(gnt_b), .o_rvalid_a(rvalid_a), .o_rvalid_b(rvalid_b),
        .o_rdata_a(rdata_a), .o_rdata_b(rdata_b),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata), .o_sel(sel), .o_busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        model_a = '0;
        model_b = '0;
        sb.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({gnt_a, gnt_b, rvalid_a, rvalid_b, mem_en, mem_we, sel, busy,
             rdata_a, rdata_b, mem_addr, mem_wdata} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h required=0", {gnt_a, gnt_b, rvalid_a, rvalid_b,
                     mem_en, mem_we, sel, busy, rdata_a, rdata_b, mem_addr, mem_wdata});
        end
        req_a = 1'b1;
        tick();
        checks++;
        if ({gnt_a, busy} !== 2'b00) begin
            failures++;
            $display("FAIL reset_holds_idle got=%b required=00", {gnt_a, busy});
        end
        req_a = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_transfers();
        txn_t       tbl[4];
        txn_t       t;
        exp_t       e;
        logic [6:0] got, req;
        tbl[0] = '{1'b0, 1'b0, 10'd5,  32'h11};
        tbl[1] = '{1'b1, 1'b0, 10'd20, 32'h22};
        tbl[2] = '{1'b1, 1'b1, 10'd7,  32'd2};
        tbl[3] = '{1'b0, 1'b1, 10'd9,  32'd3};
        for (int i = 0; i < 4; i++) begin
            t = tbl[i];
            if (t.port) begin
                req_b = 1'b1; we_b = t.we; addr_b = t.addr; wdata_b = t.wdata;
                if (!t.we) model_b = NB_DATA'(t.addr) + 32'd100;
            end else begin
                req_a = 1'b1; we_a = t.we; addr_a = t.addr; wdata_a = t.wdata;
                if (!t.we) model_a = NB_DATA'(t.addr) + 32'd100;
            end
            e.port = t.port;
            e.data = t.port ? model_b : model_a;
            sb.push_back(e);
            for (int c = 1; c <= 5; c++) begin
                tick();
                if (c == 1) begin req_a = 1'b0; req_b = 1'b0; end
                got = {gnt_a, gnt_b, rvalid_a, rvalid_b, mem_en, mem_we, busy};
                req = {(c == 1) && !t.port, (c == 1) && t.port, (c == 4) && !t.port,
                       (c == 4) && t.port, (c == 1), (c == 1) && t.we, (c <= 4)};
                checks++;
                if (got !== req) begin
                    failures++;
                    $display("FAIL single_handshake txn=%0d cycle=%0d got=%b required=%b", i, c, got, req);
                end
                if (c == 1) begin
                    checks++;
                    if ({sel, mem_addr, mem_wdata} !== {t.port, t.addr, t.wdata}) begin
                        failures++;
                        $display("FAIL single_payload txn=%0d got sel=%0d addr=%0d wdata=%0d required sel=%0d addr=%0d wdata=%0d",
                                 i, sel, mem_addr, mem_wdata, t.port, t.addr, t.wdata);
                    end
                end
                if (rvalid_a | rvalid_b) begin
                    checks++;
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL single_unexpected_rvalid txn=%0d cycle=%0d", i, c);
                    end else begin
                        e = sb.pop_front();
                        if ({rvalid_b, (rvalid_b ? rdata_b : rdata_a)} !== {e.port, e.data}) begin
                            failures++;
                            $display("FAIL single_rdata txn=%0d got port=%0d data=%0d required port=%0d data=%0d",
                                     i, rvalid_b, (rvalid_b ? rdata_b : rdata_a), e.port, e.data);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        exp_t       e;
        logic [3:0] got, req;
        do_reset();
        tick();
        addr_a = 10'd30; addr_b = 10'd40; we_a = 1'b0; we_b = 1'b0;
        req_a = 1'b1; req_b = 1'b1;
        model_a = 32'd130;
        model_b = 32'd140;
        for (int k = 0; k < 4; k++) begin
            e.port = k[0];
            e.data = k[0] ? model_b : model_a;
            sb.push_back(e);
        end
        for (int c = 1; c <= 17; c++) begin
            tick();
            if (c == 13) begin req_a = 1'b0; req_b = 1'b0; end
            got = {gnt_a, gnt_b, rvalid_a, rvalid_b};
            req = {(c == 1) || (c == 9), (c == 5) || (c == 13), (c == 4) || (c == 12), (c == 8) || (c == 16)};
            checks++;
            if (got !== req) begin
                failures++;
                $display("FAIL simul_handshake cycle=%0d got=%b required=%b", c, got, req);
            end
            if (c == 1 || c == 5 || c == 9 || c == 13) begin
                checks++;
                if (sel !== ((c == 5) || (c == 13))) begin
                    failures++;
                    $display("FAIL simul_sel cycle=%0d got=%0d required=%0d", c, sel, (c == 5) || (c == 13));
                end
            end
            if (rvalid_a | rvalid_b) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL simul_unexpected_rvalid cycle=%0d", c);
                end else begin
                    e = sb.pop_front();
                    if ({rvalid_b, (rvalid_b ? rdata_b : rdata_a)} !== {e.port, e.data}) begin
                        failures++;
                        $display("FAIL simul_rdata cycle=%0d got port=%0d data=%0d required port=%0d data=%0d",
                                 c, rvalid_b, (rvalid_b ? rdata_b : rdata_a), e.port, e.data);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t       e;
        logic [4:0] got, req;
        addr_a = 10'd50; we_a = 1'b0; req_a = 1'b1;
        for (int k = 0; k < 3; k++) begin
            e.port = 1'b0;
            e.data = 32'd150 + 32'(k);
            sb.push_back(e);
        end
        model_a = 32'd152;
        for (int c = 1; c <= 13; c++) begin
            tick();
            got = {gnt_a, gnt_b, rvalid_a, rvalid_b, busy};
            req = {(c == 1) || (c == 5) || (c == 9), 1'b0, (c == 4) || (c == 8) || (c == 12), 1'b0, (c <= 12)};
            checks++;
            if (got !== req) begin
                failures++;
                $display("FAIL b2b_handshake cycle=%0d got=%b required=%b", c, got, req);
            end
            if (gnt_a) begin
                checks++;
                if (mem_addr !== NB_ADDR'(50 + (c - 1) / 4)) begin
                    failures++;
                    $display("FAIL b2b_addr cycle=%0d got=%0d required=%0d", c, mem_addr, 50 + (c - 1) / 4);
                end
            end
            if (c == 1) addr_a = 10'd51;
            if (c == 5) addr_a = 10'd52;
            if (c == 9) req_a = 1'b0;
            if (rvalid_a | rvalid_b) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_unexpected_rvalid cycle=%0d", c);
                end else begin
                    e = sb.pop_front();
                    if ({rvalid_b, (rvalid_b ? rdata_b : rdata_a)} !== {e.port, e.data}) begin
                        failures++;
                        $display("FAIL b2b_rdata cycle=%0d got port=%0d data=%0d required port=%0d data=%0d",
                                 c, rvalid_b, (rvalid_b ? rdata_b : rdata_a), e.port, e.data);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t       e;
        logic [3:0] got, req;
        addr_a = 10'd60; we_a = 1'b0; req_a = 1'b1;
        tick();
        req_a = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt_a, gnt_b, rvalid_a, rvalid_b, mem_en, mem_we, sel, busy,
             rdata_a, rdata_b, mem_addr, mem_wdata} !== '0) begin
            failures++;
            $display("FAIL midreset_outputs got=%h required=0", {gnt_a, gnt_b, rvalid_a, rvalid_b,
                     mem_en, mem_we, sel, busy, rdata_a, rdata_b, mem_addr, mem_wdata});
        end
        model_a = '0;
        model_b = '0;
        tick();
        rst_n = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            checks++;
            if ({rvalid_a, busy} !== 2'b00) begin
                failures++;
                $display("FAIL midreset_dropped cycle=%0d got=%b required=00", c, {rvalid_a, busy});
            end
        end
        addr_a = 10'd61; addr_b = 10'd62; req_a = 1'b1; req_b = 1'b1;
        e.port = 1'b0; e.data = 32'd161; sb.push_back(e);
        e.port = 1'b1; e.data = 32'd162; sb.push_back(e);
        model_a = 32'd161;
        model_b = 32'd162;
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (c == 1) req_a = 1'b0;
            if (c == 5) req_b = 1'b0;
            got = {gnt_a, gnt_b, rvalid_a, rvalid_b};
            req = {(c == 1), (c == 5), (c == 4), (c == 8)};
            checks++;
            if (got !== req) begin
                failures++;
                $display("FAIL midreset_order cycle=%0d got=%b required=%b", c, got, req);
            end
            if (rvalid_a | rvalid_b) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL midreset_unexpected_rvalid cycle=%0d", c);
                end else begin
                    e = sb.pop_front();
                    if ({rvalid_b, (rvalid_b ? rdata_b : rdata_a)} !== {e.port, e.data}) begin
                        failures++;
                        $display("FAIL midreset_rdata cycle=%0d got port=%0d data=%0d required port=%0d data=%0d",
                                 c, rvalid_b, (rvalid_b ? rdata_b : rdata_a), e.port, e.data);
                    end
                end
            end
        end
    endtask

    task automatic test_late_req();
        exp_t       e;
        logic [4:0] got, req;
        addr_a = 10'd70; we_a = 1'b0; req_a = 1'b1;
        e.port = 1'b0; e.data = 32'd170; sb.push_back(e);
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (c == 1) req_a = 1'b0;
            if (c == 2) begin
                addr_b = 10'd80; we_b = 1'b0; req_b = 1'b1;
                e.port = 1'b1; e.data = 32'd180; sb.push_back(e);
            end
            if (c == 5) req_b = 1'b0;
            got = {gnt_a, gnt_b, rvalid_a, rvalid_b, sel};
            req = {(c == 1), (c == 5), (c == 4), (c == 8), (c >= 5)};
            checks++;
            if (got !== req) begin
                failures++;
                $display("FAIL late_req cycle=%0d got=%b required=%b", c, got, req);
            end
            if (rvalid_a | rvalid_b) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL late_unexpected_rvalid cycle=%0d", c);
                end else begin
                    e = sb.pop_front();
                    if ({rvalid_b, (rvalid_b ? rdata_b : rdata_a)} !== {e.port, e.data}) begin
                        failures++;
                        $display("FAIL late_rdata cycle=%0d got port=%0d data=%0d required port=%0d data=%0d",
                                 c, rvalid_b, (rvalid_b ? rdata_b : rdata_a), e.port, e.data);
                    end
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_transfers();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
        test_late_req();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d pending required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
